// File: rtl/arm_dp_sequencer_if.sv
// Execute-stage bus for arm_dp_sequencer: instruction handshake, register-file ports, ALU ports, writeback.
// slave = the sequencer, master = its surroundings (fetch/decode, register file, ALU, CPSR).
interface arm_dp_sequencer_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_rn_sel;
    logic [3:0]  rf_rm_sel;
    logic [31:0] rf_rn_data;
    logic [31:0] rf_rm_data;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_op_sel;
    logic [31:0] alu_out;
    logic [31:0] alu_cpsr_next;
    logic [31:0] cpsr_prev;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_sel;
    logic [31:0] rf_wr_data;
    logic        cpsr_we;
    logic [31:0] cpsr_wr_data;
    logic        done;
    logic        skipped;
    logic        illegal;

    modport slave (
        input  instr_valid, instr, rf_rn_data, rf_rm_data, alu_out, alu_cpsr_next, cpsr_prev,
        output instr_ready, rf_rn_sel, rf_rm_sel, alu_op1, alu_op2, alu_op_sel,
               rf_wr_en, rf_wr_sel, rf_wr_data, cpsr_we, cpsr_wr_data, done, skipped, illegal
    );

    modport master (
        output instr_valid, instr, rf_rn_data, rf_rm_data, alu_out, alu_cpsr_next, cpsr_prev,
        input  instr_ready, rf_rn_sel, rf_rm_sel, alu_op1, alu_op2, alu_op_sel,
               rf_wr_en, rf_wr_sel, rf_wr_data, cpsr_we, cpsr_wr_data, done, skipped, illegal
    );
endinterface

// File: rtl/arm_dp_sequencer.sv
// Multi-cycle sequencer running one ARM data-processing instruction through the shared ALU.
//   state | meaning
//   IDLE  | ready; decode legality and condition on accept
//   READ  | register-file read, RF_RD_LAT cycles
//   EXEC  | drive ALU, register its result and CPSR
//   WB    | write Rd and/or CPSR, pulse done
//   FIN   | done pulse for skipped or illegal, no writes
module arm_dp_sequencer #(
    parameter int RF_RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    arm_dp_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, FIN} state_t;

    state_t      state, state_nxt;
    logic [25:0] ir;
    logic [1:0]  rd_cnt;
    logic [31:0] rn_q, op2_q, res_q, cpsr_q;
    logic        fin_skip, fin_ill;
    logic        bad_form, cond_ok;
    logic [63:0] imm_rot;
    logic [31:0] imm_op2;

    logic        ready, done, skipped, illegal, wr_en, cpsr_we;
    logic [31:0] op1, op2;

    logic unused_bits;
    assign unused_bits = ^{bus.cpsr_prev[27:0], bus.instr[27:26]};

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: cond_pass = z;
            4'h1: cond_pass = !z;
            4'h2: cond_pass = cy;
            4'h3: cond_pass = !cy;
            4'h4: cond_pass = n;
            4'h5: cond_pass = !n;
            4'h6: cond_pass = v;
            4'h7: cond_pass = !v;
            4'h8: cond_pass = cy && !z;
            4'h9: cond_pass = !cy || z;
            4'hA: cond_pass = (n == v);
            4'hB: cond_pass = (n != v);
            4'hC: cond_pass = !z && (n == v);
            4'hD: cond_pass = z || (n != v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign bad_form = (bus.instr[27:26] != 2'b00) || (!bus.instr[25] && (bus.instr[11:4] != 8'h00));
    assign cond_ok  = cond_pass(bus.instr[31:28], bus.cpsr_prev[31:28]);

    // Immediate operand: 8-bit value rotated right by twice the 4-bit rotate field.
    assign imm_rot = {24'h0, ir[7:0], 24'h0, ir[7:0]} >> {ir[11:8], 1'b0};
    assign imm_op2 = imm_rot[31:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        skipped   = 1'b0;
        illegal   = 1'b0;
        wr_en     = 1'b0;
        cpsr_we   = 1'b0;
        op1       = 32'h0;
        op2       = 32'h0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.instr_valid) state_nxt = (bad_form || !cond_ok) ? FIN : READ;
            end
            READ: if (rd_cnt == 2'd0) state_nxt = EXEC;
            EXEC: begin
                op1       = rn_q;
                op2       = op2_q;
                state_nxt = WB;
            end
            WB: begin
                done      = 1'b1;
                wr_en     = (ir[24:23] != 2'b10);
                cpsr_we   = ir[20];
                state_nxt = IDLE;
            end
            FIN: begin
                done      = 1'b1;
                skipped   = fin_skip;
                illegal   = fin_ill;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir       <= '0;
            rd_cnt   <= '0;
            rn_q     <= '0;
            op2_q    <= '0;
            res_q    <= '0;
            cpsr_q   <= '0;
            fin_skip <= 1'b0;
            fin_ill  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.instr_valid) begin
                    ir       <= bus.instr[25:0];
                    rd_cnt   <= 2'(RF_RD_LAT - 1);
                    fin_ill  <= bad_form;
                    fin_skip <= !bad_form && !cond_ok;
                end
                READ: begin
                    if (rd_cnt != 2'd0) begin
                        rd_cnt <= rd_cnt - 2'd1;
                    end else begin
                        rn_q  <= bus.rf_rn_data;
                        op2_q <= ir[25] ? imm_op2 : bus.rf_rm_data;
                    end
                end
                // Registered so writeback never depends on the live ALU/CPSR path.
                EXEC: begin
                    res_q  <= bus.alu_out;
                    cpsr_q <= bus.alu_cpsr_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready  = ready;
    assign bus.rf_rn_sel    = ir[19:16];
    assign bus.rf_rm_sel    = ir[3:0];
    assign bus.alu_op1      = op1;
    assign bus.alu_op2      = op2;
    assign bus.alu_op_sel   = ir[24:21];
    assign bus.rf_wr_en     = wr_en;
    assign bus.rf_wr_sel    = ir[15:12];
    assign bus.rf_wr_data   = res_q;
    assign bus.cpsr_we      = cpsr_we;
    assign bus.cpsr_wr_data = cpsr_q;
    assign bus.done         = done;
    assign bus.skipped      = skipped;
    assign bus.illegal      = illegal;

endmodule
